// File: rtl/fc0_gradient_streamer_pkg.sv
// Shared types and sizing for the FC0 gradient streamer.
// Default sizes come from `FC0_NEURONS and `PREC. If either macro is undefined, it falls back to 64 or 16.
`ifndef FC0_NEURONS
`define FC0_NEURONS 64
`endif
`ifndef PREC
`define PREC 16
`endif

package fc0_gradient_streamer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int N_NEURONS_DEF = `FC0_NEURONS;
  localparam int LANES_DEF     = 8;
  localparam int PREC_DEF      = `PREC;
  localparam int BEATS         = N_NEURONS_DEF / LANES_DEF;

  // A single-beat vector still needs a one-bit beat index.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEAT_W = beat_w(BEATS);

endpackage

// File: rtl/fc0_gradient_streamer_if.sv
// Beat stream from the gradient streamer to the FC0 backprop stage.
// The handshake is valid/ready.
interface fc0_gradient_streamer_if
  import fc0_gradient_streamer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PREC  = PREC_DEF,
  parameter int BW    = BEAT_W
) ();
  logic [LANES-1:0][PREC-1:0] grad_o;
  logic [BW-1:0]              beat_id_o;
  logic                       valid_o;
  logic                       last_o;
  logic                       ready_i;

  modport master (output grad_o, beat_id_o, valid_o, last_o, input ready_i);
  modport slave  (input grad_o, beat_id_o, valid_o, last_o, output ready_i);
endinterface

// File: rtl/fc0_gradient_streamer_relu_grad_mask.sv
// ReLU derivative for one neuron.
// The gradient passes through only when the forward activation is strictly positive.
module relu_grad_mask
  import fc0_gradient_streamer_pkg::*;
#(
  parameter int PREC = PREC_DEF
) (
  input  logic [PREC-1:0] grad_i,
  input  logic [PREC-1:0] act_i,
  output logic [PREC-1:0] grad_o
);
  assign grad_o = ($signed(act_i) > 0) ? grad_i : '0;
endmodule

// File: rtl/fc0_gradient_streamer.sv
// Snapshots the completed FC0 gradient vector and streams it out as LANES-wide beats.
// When RELU_DERIV_EN is defined, the ReLU derivative mask is applied at capture.
module fc0_gradient_streamer
  import fc0_gradient_streamer_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int PREC      = PREC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           forward,
  input  logic [N_NEURONS-1:0][PREC-1:0] pl_gradients_i,
  input  logic                           pl_grad_valid_i,
  input  logic [N_NEURONS-1:0][PREC-1:0] activations_i,
  output logic                           busy_o,
  fc0_gradient_streamer_if.master        strm
);
  localparam int BEATS_L = N_NEURONS / LANES;
  localparam int BW      = beat_w(BEATS_L);

  // state  | meaning
  // IDLE   | waiting for a rising edge of pl_grad_valid_i
  // STREAM | presenting buffer[beat] until the last beat is accepted
  state_e                               state_q, state_d;
  logic                                 prev_valid_q, start_q;
  logic [BW-1:0]                        beat_q, beat_d;
  logic [BEATS_L-1:0][LANES*PREC-1:0]   buffer_q;
  logic [N_NEURONS-1:0][PREC-1:0]       masked;
  logic                                 capture, valid, last, hs;

`ifdef RELU_DERIV_EN
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_mask
    relu_grad_mask #(.PREC(PREC)) u_mask (
      .grad_i (pl_gradients_i[i]),
      .act_i  (activations_i[i]),
      .grad_o (masked[i])
    );
  end
`else
  logic unused_activations;
  assign unused_activations = ^activations_i;
  assign masked = pl_gradients_i;
`endif

  // The edge is registered, so the capture happens one cycle after the flag is first seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      prev_valid_q <= pl_grad_valid_i;
      start_q      <= pl_grad_valid_i & ~prev_valid_q & ~forward;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q <= '0;
    end else if (capture) begin
      buffer_q <= masked;
    end
  end

  assign hs = valid & strm.ready_i;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_q && !forward) begin
          state_d = STREAM;
          beat_d  = '0;
          capture = 1'b1;
        end
      end
      STREAM: begin
        if (forward) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (hs && last) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (hs) begin
          beat_d  = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    valid          = (state_q == STREAM);
    last           = valid & (beat_q == BW'(BEATS_L - 1));
    busy_o         = valid;
    strm.valid_o   = valid;
    strm.last_o    = last;
    strm.beat_id_o = beat_q;
    strm.grad_o    = valid ? buffer_q[beat_q] : '0;
  end

endmodule

// File: tb/tb_fc0_gradient_streamer.sv
// Directed bench for fc0_gradient_streamer at N=64, LANES=8, PREC=16.
// Expected values are hand-set per test in exp_mem.
module tb_fc0_gradient_streamer;
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                forward = 1'b0;
  logic [63:0][15:0]   grads = '0;
  logic [63:0][15:0]   acts = '0;
  logic                gvalid = 1'b0;
  logic                busy;
  logic [15:0]         exp_mem [64];
  int                  checks = 0;
  int                  errors = 0;

  fc0_gradient_streamer_if #(.LANES(8), .PREC(16), .BW(3)) sif ();

  fc0_gradient_streamer #(.N_NEURONS(64), .LANES(8), .PREC(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .forward         (forward),
    .pl_gradients_i  (grads),
    .pl_grad_valid_i (gvalid),
    .activations_i   (acts),
    .busy_o          (busy),
    .strm            (sif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int k);
    chk({tag, " valid"}, {31'd0, sif.valid_o}, 32'd1);
    chk({tag, " busy"},  {31'd0, busy}, 32'd1);
    chk({tag, " beat_id"}, {29'd0, sif.beat_id_o}, k);
    chk({tag, " last"},  {31'd0, sif.last_o}, (k == 7) ? 32'd1 : 32'd0);
    for (int l = 0; l < 8; l++)
      chk($sformatf("%s b%0d l%0d", tag, k, l), {16'd0, sif.grad_o[l]}, {16'd0, exp_mem[8*k+l]});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, {31'd0, sif.valid_o}, 32'd0);
    chk({tag, " last"},  {31'd0, sif.last_o}, 32'd0);
    chk({tag, " busy"},  {31'd0, busy}, 32'd0);
    chk({tag, " beat_id"}, {29'd0, sif.beat_id_o}, 32'd0);
    chk({tag, " grad"}, {31'd0, |sif.grad_o}, 32'd0);
  endtask

  // A one-cycle pulse. After it, beat 0 is visible.
  task automatic pulse_start();
    gvalid = 1'b1;
    tick();
    chk("latency", {31'd0, sif.valid_o}, 32'd0);
    gvalid = 1'b0;
    tick();
  endtask

  task automatic load_ramp(input logic [15:0] off);
    for (int i = 0; i < 64; i++) begin
      grads[i]   = 16'(i) + off;
      acts[i]    = 16'd1;
      exp_mem[i] = 16'(i) + off;
    end
  endtask

  initial begin
    int nbeats;
    int nlast;
    sif.ready_i = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // Basic ramp
    load_ramp(16'h0000);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk_beat("basic", k);
      tick();
    end
    chk_idle("basic_done");

    // Mask pattern: odd activations positive, even ones negative, neuron 0 zero
    for (int i = 0; i < 64; i++) begin
      grads[i] = 16'h0100;
      acts[i]  = (i % 2 == 1) ? 16'd5 : -16'sd3;
`ifdef RELU_DERIV_EN
      exp_mem[i] = (i % 2 == 1) ? 16'h0100 : 16'h0000;
`else
      exp_mem[i] = 16'h0100;
`endif
    end
    acts[0] = 16'd0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk_beat("mask", k);
      tick();
    end
    chk_idle("mask_done");

    // Backpressure on beat 2
    load_ramp(16'h0300);
    pulse_start();
    chk_beat("bp", 0); tick();
    chk_beat("bp", 1); tick();
    sif.ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_beat("bp_hold", 2);
      tick();
    end
    sif.ready_i = 1'b1;
    for (int k = 2; k < 8; k++) begin
      chk_beat("bp", k);
      tick();
    end
    chk_idle("bp_done");

    // Abort during beat 4, then restart with new data
    load_ramp(16'h0200);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      chk_beat("abort", k);
      if (k < 4) tick();
    end
    forward = 1'b1;
    tick();
    chk_idle("abort_idle");
    forward = 1'b0;
    tick();
    chk_idle("abort_stay");
    load_ramp(16'h0400);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk_beat("restart", k);
      tick();
    end
    chk_idle("restart_done");

    // A held flag must produce exactly one stream
    load_ramp(16'h0500);
    nbeats = 0;
    nlast  = 0;
    gvalid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c == 20) gvalid = 1'b0;
      if (sif.valid_o && sif.ready_i) nbeats++;
      if (sif.valid_o && sif.ready_i && sif.last_o) nlast++;
      tick();
    end
    chk("held_beats", nbeats, 32'd8);
    chk("held_lasts", nlast, 32'd1);

    // A second edge during a stream is ignored
    load_ramp(16'h0600);
    pulse_start();
    chk_beat("ign", 0); tick();
    chk_beat("ign", 1); tick();
    for (int i = 0; i < 64; i++) grads[i] = 16'h7000 + 16'(i);
    chk_beat("ign", 2);
    gvalid = 1'b1;
    tick();
    gvalid = 1'b0;
    for (int k = 3; k < 8; k++) begin
      chk_beat("ign", k);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      chk_idle("ign_after");
      tick();
    end

    // Reset at beat 3
    load_ramp(16'h0800);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      chk_beat("rst_mid", k);
      if (k < 3) tick();
    end
    rst = 1'b1;
    tick();
    chk_idle("rst_mid_idle");
    rst = 1'b0;
    tick();
    chk_idle("rst_mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
